// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver with FWFT byte FIFO.
package uart_rx_pkg;

  localparam int DATA_W           = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int HALF_BIT         = DEF_CLKS_PER_BIT / 2;
  localparam int CNT_W            = $clog2(DEF_CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Mid-bit offset used to centre the start-bit check for a given bit period.
  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

  // Width of a counter that spans one bit period.
  function automatic int cnt_width(input int cpb);
    return $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO. The head byte is held in a register so that
// data_o keeps its last value while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] head_reg;

  logic             do_pop;
  logic             do_push;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      remain;

  // A full FIFO still accepts a write when the same edge frees a slot.
  assign do_pop      = pop && (count_reg != '0);
  assign do_push     = push && ((count_reg != DEPTH_C) || do_pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
  assign remain      = count_reg - (AW+1)'(do_pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // If nothing older survives this edge, the incoming word becomes head.
      if (remain != '0)  head_reg <= mem[rd_ptr_next];
      else if (do_push)  head_reg <= wdata;
    end
  end

  assign rdata = head_reg;
  assign valid = (count_reg != '0);
  assign full  = (count_reg == DEPTH_C);
  assign count = count_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, idle high) feeding a small FWFT byte FIFO,
// with sticky frame-error and overflow flags.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          rx_i,
  input  logic                          rd_en_i,
  input  logic                          clr_err_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overflow_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  logic              sync_meta_reg;
  logic              sync_rx_reg;
  rx_state_t         state_reg, state_next;
  logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              push_req_reg, push_req_next;
  logic              ferr_set;
  logic              frame_err_reg;
  logic              overflow_reg;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_valid;
  logic              ovf_set;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_reg <= 1'b1;
      sync_rx_reg   <= 1'b1;
    end else begin
      sync_meta_reg <= rx_i;
      sync_rx_reg   <= sync_meta_reg;
    end
  end

  // Receiver state, bit timing, shift register and pending-push registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      push_req_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      push_req_reg <= push_req_next;
    end
  end

  // Next-state logic: start bit checked mid-bit, data and stop bits one
  // full bit period apart from there.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    push_req_next = 1'b0;
    ferr_set      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!sync_rx_reg) begin
          state_next   = START;
          bit_cnt_next = '0;
        end
      end
      START: begin
        if (bit_cnt_reg == HALF_M1) begin
          if (sync_rx_reg) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_cnt_next = '0;
            bit_idx_next = '0;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt_reg == LAST) begin
          bit_cnt_next            = '0;
          shift_next[bit_idx_reg] = sync_rx_reg;
          if (bit_idx_reg == 3'd7) state_next   = STOP;
          else                     bit_idx_next = bit_idx_reg + 1'b1;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt_reg == LAST) begin
          bit_cnt_next = '0;
          if (sync_rx_reg) begin
            push_req_next = 1'b1;
            state_next    = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A line stuck low must not look like a stream of start bits.
        if (sync_rx_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!ena) begin
      state_next    = IDLE;
      push_req_next = 1'b0;
      ferr_set      = 1'b0;
    end
  end

  assign fifo_push = push_req_reg && ena;
  assign fifo_pop  = rd_en_i && fifo_valid;
  assign ovf_set   = fifo_push && fifo_full && !fifo_pop;

  // Sticky error flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      frame_err_reg <= ferr_set | (frame_err_reg & ~clr_err_i);
      overflow_reg  <= ovf_set  | (overflow_reg  & ~clr_err_i);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (shift_reg),
    .pop   (fifo_pop),
    .rdata (data_o),
    .valid (fifo_valid),
    .full  (fifo_full),
    .count (count_o)
  );

  assign valid_o     = fifo_valid;
  assign frame_err_o = frame_err_reg;
  assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the receiver and FIFO.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Edges from the negedge where the start bit is driven to the stop-bit
  // sample (2 synchronizer edges + detect edge + half bit + 9 bits), and
  // one more to the FIFO write.
  localparam int STOP_EDGE = 3 + CPB/2 + 9*CPB;
  localparam int PUSH_EDGE = STOP_EDGE + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       rx_i = 1'b1;
  logic       rd_en_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic [2:0] count_o;
  logic       frame_err_o;
  logic       overflow_o;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .rx_i        (rx_i),
    .rd_en_i     (rd_en_i),
    .clr_err_i   (clr_err_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [7:0] q[$];
  logic [7:0] m_data = 8'h00;
  bit         m_ferr = 1'b0;
  bit         m_ovf  = 1'b0;
  int         cyc = 0;
  logic       s_rd = 1'b0, s_clr = 1'b0, s_rst = 1'b0;
  int         push_cyc = -1;
  int         ferr_cyc = -1;
  logic [7:0] push_byte = 8'h00;
  bit         chk_en = 1'b0;
  bit         rnd_done = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Capture what the DUT saw at each rising edge.
  initial forever begin
    @(posedge clk);
    cyc   = cyc + 1;
    s_rd  = rd_en_i;
    s_clr = clr_err_i;
    s_rst = rst_n;
  end

  // Advance the model by the edge just taken, then compare all outputs.
  initial forever begin
    bit ovf_set, ferr_set;
    @(negedge clk);
    #1;
    ovf_set  = 1'b0;
    ferr_set = 1'b0;
    if (s_rst === 1'b1) begin
      if (s_rd && q.size() > 0) void'(q.pop_front());
      if (cyc == push_cyc) begin
        if (q.size() < DEPTH) q.push_back(push_byte);
        else                  ovf_set = 1'b1;
        push_cyc = -1;
      end
      if (cyc == ferr_cyc) begin
        ferr_set = 1'b1;
        ferr_cyc = -1;
      end
      if (s_clr) begin
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
      end
      if (ferr_set) m_ferr = 1'b1;
      if (ovf_set)  m_ovf  = 1'b1;
      if (q.size() > 0) m_data = q[0];
    end
    if (rst_n === 1'b0) begin
      q.delete();
      m_data   = 8'h00;
      m_ferr   = 1'b0;
      m_ovf    = 1'b0;
      push_cyc = -1;
      ferr_cyc = -1;
    end
    if (chk_en) begin
      check("valid_o", 8'(valid_o), 8'(q.size() != 0));
      check("count_o", 8'(count_o), 8'(q.size()));
      check("data_o", data_o, m_data);
      check("frame_err_o", 8'(frame_err_o), 8'(m_ferr));
      check("overflow_o", 8'(overflow_o), 8'(m_ovf));
    end
  end

  // Must be called exactly at a falling edge; returns at a falling edge.
  task automatic send(input logic [7:0] b, input bit stop_ok, input bit expect_it);
    if (expect_it) begin
      push_byte = b;
      if (stop_ok) push_cyc = cyc + PUSH_EDGE;
      else         ferr_cyc = cyc + STOP_EDGE;
    end
    $display("frame %02h stop=%0d expected=%0d at cycle %0d", b, stop_ok, expect_it, cyc);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      repeat (40) @(negedge clk);
      rx_i = 1'b1;
    end
  endtask

  task automatic pop_check(input logic [7:0] exp);
    @(negedge clk);
    #2;
    check("pop_head", data_o, exp);
    rd_en_i = 1'b1;
    @(negedge clk);
    rd_en_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #2;
    check("rst_data", data_o, 8'h00);
    check("rst_count", 8'(count_o), 8'd0);
    check("rst_flags", {6'b0, frame_err_o, overflow_o}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte, then pop
    send(8'hA5, 1'b1, 1'b1);
    #2;
    check("a5_data", data_o, 8'hA5);
    check("a5_valid", 8'(valid_o), 8'd1);
    check("a5_count", 8'(count_o), 8'd1);
    rd_en_i = 1'b1;
    @(negedge clk);
    rd_en_i = 1'b0;
    #2;
    check("a5_popped_count", 8'(count_o), 8'd0);
    check("a5_popped_valid", 8'(valid_o), 8'd0);

    // Glitch on the line: false start
    @(negedge clk);
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (200) @(negedge clk);
    #2;
    check("glitch_count", 8'(count_o), 8'd0);
    check("glitch_ferr", 8'(frame_err_o), 8'd0);

    // Framing error, recovery, clear
    @(negedge clk);
    send(8'h3C, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    #2;
    check("ferr_set", 8'(frame_err_o), 8'd1);
    check("ferr_count", 8'(count_o), 8'd0);
    @(negedge clk);
    send(8'h11, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    check("after_ferr_data", data_o, 8'h11);
    pop_check(8'h11);
    pulse_clr();
    #2;
    check("ferr_cleared", 8'(frame_err_o), 8'd0);

    // Overflow: five bytes into four slots
    for (int b = 1; b <= 5; b++) begin
      @(negedge clk);
      send(8'(b), 1'b1, 1'b1);
    end
    repeat (3) @(negedge clk);
    #2;
    check("ovf_count", 8'(count_o), 8'd4);
    check("ovf_flag", 8'(overflow_o), 8'd1);
    pop_check(8'h01);
    pop_check(8'h02);
    pop_check(8'h03);
    pop_check(8'h04);
    #2;
    check("ovf_drained", 8'(count_o), 8'd0);

    // Full FIFO, pop in the exact push cycle
    pulse_clr();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      send(8'h21 + 8'(b), 1'b1, 1'b1);
    end
    @(negedge clk);
    fork
      send(8'h77, 1'b1, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) @(negedge clk);
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    #2;
    check("full_pp_count", 8'(count_o), 8'd4);
    check("full_pp_ovf", 8'(overflow_o), 8'd0);
    pop_check(8'h22);
    pop_check(8'h23);
    pop_check(8'h24);
    pop_check(8'h77);

    // Reset in the middle of bit 4 of a frame
    @(negedge clk);
    send(8'h55, 1'b1, 1'b1);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB + 4*CPB + CPB/2) @(negedge clk);
    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("midrst_count", 8'(count_o), 8'd0);
    check("midrst_data", data_o, 8'h00);
    check("midrst_valid", 8'(valid_o), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(8'hC3, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    check("postrst_data", data_o, 8'hC3);
    check("postrst_count", 8'(count_o), 8'd1);
    pop_check(8'hC3);

    // Receiver parked by ena=0
    @(negedge clk);
    ena = 1'b0;
    send(8'h99, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    check("parked_count", 8'(count_o), 8'd0);
    @(negedge clk);
    ena = 1'b1;
    repeat (5) @(negedge clk);

    // Randomized traffic with random reads and clears
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          logic [7:0] b;
          bit ok;
          b  = 8'($urandom);
          ok = ($urandom_range(0, 7) != 0);
          repeat ($urandom_range(1, 20)) @(negedge clk);
          send(b, ok, 1'b1);
        end
        repeat (10) @(negedge clk);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          rd_en_i   = ($urandom_range(0, 99) < 4);
          clr_err_i = ($urandom_range(0, 199) == 0);
        end
        rd_en_i   = 1'b0;
        clr_err_i = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
